// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// i2c_master : single-byte I2C initiator (write or read), open-drain, stretching
// Revision   : 1.0
// ============================================================================
module i2c_master #(
  parameter int CLKDIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       nack,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int               CNT_W   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_AACK  = 3'd3,
    S_DATA  = 3'd4,
    S_DACK  = 3'd5,
    S_STOP  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             nack_q, nack_d;
  logic             scl_low_q, scl_low_d;
  logic             sda_low_q, sda_low_d;

  logic accept;
  logic busy;
  logic stall;
  logic tick;
  logic sample;
  logic slot_end;

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rdata     = rdata_q;
  assign nack      = nack_q;

  assign scl = scl_low_q ? 1'b0 : 1'bz;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  // Released but still low means a slave is stretching: hold the quarter timer.
  assign accept   = cmd_valid && cmd_ready;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign stall    = busy && !scl_low_q && !scl;
  assign tick     = busy && !stall && (cnt_q == CNT_MAX);
  assign sample   = tick && (qtr_q == 2'd2);
  assign slot_end = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;

    if (accept) begin
      state_d = S_START;
      cnt_d   = '0;
      qtr_d   = 2'd0;
      bit_d   = 3'd0;
      addr_d  = {cmd_addr, cmd_rw};
      wdata_d = cmd_wdata;
      nack_d  = 1'b0;
    end else if (busy && !stall) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    if (sample) begin
      case (state_q)
        S_AACK:  if (sda) nack_d = 1'b1;
        S_DATA:  if (addr_q[0]) rdata_d = {rdata_q[6:0], sda};
        S_DACK:  if (!addr_q[0] && sda) nack_d = 1'b1;
        default: ;
      endcase
    end

    if (slot_end) begin
      bit_d = ((state_q == S_ADDR) || (state_q == S_DATA)) ? bit_q + 3'd1 : 3'd0;
      case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR:  if (bit_q == 3'd7) state_d = S_AACK;
        S_AACK:  state_d = nack_q ? S_STOP : S_DATA;
        S_DATA:  if (bit_q == 3'd7) state_d = S_DACK;
        S_DACK:  state_d = S_STOP;
        S_STOP:  state_d = S_DONE;
        default: ;
      endcase
    end

    if (state_q == S_DONE) state_d = S_IDLE;
  end

  // SCL follows the next state so quarter boundaries land exactly on ticks.
  always_comb begin
    scl_low_d = 1'b0;
    case (state_d)
      S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP: scl_low_d = !qtr_d[1];
      default:                                scl_low_d = 1'b0;
    endcase
  end

  // SDA is decoded from the current state, so it moves one clk after SCL falls.
  always_comb begin
    sda_low_d = 1'b0;
    case (state_q)
      S_START: sda_low_d = qtr_q[1];
      S_ADDR:  sda_low_d = !addr_q[3'd7 - bit_q];
      S_DATA:  sda_low_d = !addr_q[0] && !wdata_q[3'd7 - bit_q];
      S_STOP:  sda_low_d = (qtr_q != 2'd3);
      default: sda_low_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
// tb_i2c_master : directed bench with a bus monitor and a simple slave at 7'h21
// Revision      : 1.0
// ============================================================================
module tb_i2c_master;

  localparam int CLKDIV = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr  = 7'h00;
  logic       cmd_rw    = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready;
  logic [7:0] rdata;
  logic       done;
  logic       nack;
  wire        scl;
  wire        sda;

  logic slv_scl_low = 1'b0;
  logic slv_sda_low = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = slv_scl_low ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  i2c_master #(.CLKDIV(CLKDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rdata     (rdata),
    .done      (done),
    .nack      (nack),
    .scl       (scl),
    .sda       (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave: bits[17-k] holds the value seen at the k-th SCL rise.
  logic        prev_scl  = 1'b1;
  logic        prev_sda  = 1'b1;
  int          rise_cnt  = 0;
  int          starts    = 0;
  int          stops     = 0;
  logic [17:0] bits      = '0;
  logic [6:0]  slv_addr  = 7'h21;
  logic [7:0]  slv_rdata = 8'hA5;

  always @(negedge clk) begin
    if (prev_scl && scl && prev_sda && !sda) begin
      starts      = starts + 1;
      rise_cnt    = 0;
      slv_sda_low = 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stops       = stops + 1;
      slv_sda_low = 1'b0;
    end else if (!prev_scl && scl) begin
      if (rise_cnt < 18) bits[5'(17 - rise_cnt)] = sda;
      rise_cnt = rise_cnt + 1;
    end else if (prev_scl && !scl) begin
      slv_sda_low = 1'b0;
      if (bits[17:11] == slv_addr) begin
        if (rise_cnt == 8)
          slv_sda_low = 1'b1;
        else if (rise_cnt >= 9 && rise_cnt <= 16 && bits[10])
          slv_sda_low = !slv_rdata[3'(16 - rise_cnt)];
        else if (rise_cnt == 17 && !bits[10])
          slv_sda_low = 1'b1;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  int vectors     = 0;
  int miscompares = 0;
  int acc         = 0;
  int st0         = 0;
  int sp0         = 0;
  int dc          = 0;
  int br          = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    st0 = starts;
    sp0 = stops;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 1000), 1);
    @(posedge clk);
    #1;
    acc       = cyc;
    cmd_valid = keep;
    chk("ready_drop", cmd_ready, 0);
  endtask

  // Returns the index of the cycle in which done is high (accepting cycle = 0).
  task automatic wait_done(output int dcyc, output int busy_rdy);
    busy_rdy = 0;
    while (!done && (cyc - acc) < 5000) begin
      @(posedge clk);
      #1;
      if (cmd_ready && !done) busy_rdy++;
    end
    dcyc = cyc - acc + 1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: write 0x80 to 0x21, acknowledged
    issue(7'h21, 1'b0, 8'h80, 1'b0);
    wait_done(dc, br);
    chk("t1_done_cyc", dc, 321);
    chk("t1_nack", nack, 0);
    chk("t1_addr_byte", bits[17:10], 8'h42);
    chk("t1_aack", bits[9], 0);
    chk("t1_data_byte", bits[8:1], 8'h80);
    chk("t1_dack", bits[0], 0);
    chk("t1_starts", starts - st0, 1);
    chk("t1_stops", stops - sp0, 1);
    @(posedge clk);
    #1;
    chk("t1_ready_back", cmd_ready, 1);
    chk("t1_done_pulse", done, 0);

    // 2: read from 0x21, slave returns 0xA5
    issue(7'h21, 1'b1, 8'h00, 1'b0);
    wait_done(dc, br);
    chk("t2_done_cyc", dc, 321);
    chk("t2_rdata", rdata, 8'hA5);
    chk("t2_nack", nack, 0);
    chk("t2_addr_byte", bits[17:10], 8'h43);
    chk("t2_bus_data", bits[8:1], 8'hA5);
    chk("t2_master_nack", bits[0], 1);
    chk("t2_stops", stops - sp0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_rdata_hold", rdata, 8'hA5);

    // 3: no slave at 0x10; a request pulsed while busy must be ignored
    issue(7'h10, 1'b0, 8'h00, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmd_addr  = 7'h21;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(dc, br);
    chk("t3_done_cyc", dc, 177);
    chk("t3_nack", nack, 1);
    chk("t3_addr_byte", bits[17:10], 8'h20);
    chk("t3_aack", bits[9], 1);
    chk("t3_stops", stops - sp0, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_idle_ready", cmd_ready, 1);
    chk("t3_no_restart", starts - st0, 1);
    chk("t3_nack_held", nack, 1);

    // 4: slave stretches SCL for 10 cycles in the 3rd address bit
    issue(7'h21, 1'b0, 8'h3C, 1'b0);
    chk("t4_nack_clr", nack, 0);
    while ((cyc - acc) < 54) begin
      @(posedge clk);
      #1;
    end
    slv_scl_low = 1'b1;
    while ((cyc - acc) < 66) begin
      @(posedge clk);
      #1;
    end
    slv_scl_low = 1'b0;
    wait_done(dc, br);
    chk("t4_done_cyc", dc, 331);
    chk("t4_addr_byte", bits[17:10], 8'h42);
    chk("t4_data_byte", bits[8:1], 8'h3C);
    chk("t4_starts", starts - st0, 1);
    chk("t4_stops", stops - sp0, 1);

    // 5: reset in the middle of the data byte (4th data bit, SCL low)
    issue(7'h21, 1'b0, 8'h00, 1'b0);
    while ((cyc - acc) < 210) begin
      @(posedge clk);
      #1;
    end
    chk("t5_pre_scl", scl, 0);
    chk("t5_pre_sda", sda, 0);
    reset = 1'b0;
    #1;
    chk("t5_rst_scl", scl, 1);
    chk("t5_rst_sda", sda, 1);
    chk("t5_rst_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_ready", cmd_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_nack", nack, 0);

    // 6: cmd_valid held across two commands
    issue(7'h21, 1'b0, 8'h5A, 1'b1);
    cmd_rw = 1'b1;
    wait_done(dc, br);
    chk("t6a_done_cyc", dc, 321);
    chk("t6a_busy_ready", br, 0);
    chk("t6a_data_byte", bits[8:1], 8'h5A);
    @(posedge clk);
    #1;
    chk("t6_ready_after_done", cmd_ready, 1);
    @(posedge clk);
    #1;
    chk("t6_second_accepted", cmd_ready, 0);
    acc       = cyc;
    cmd_valid = 1'b0;
    wait_done(dc, br);
    chk("t6b_done_cyc", dc, 321);
    chk("t6b_rdata", rdata, 8'hA5);
    chk("t6b_addr_byte", bits[17:10], 8'h43);
    chk("t6b_nack", nack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
